pipeline_stage_skid: RTL and testbench
======================================

PIPELINE_STAGE_SKID -- requirements
Module: pipeline_stage_skid

Interface
REQ-001 Parameter DATA_W, default 32, width of the datapath payload (PC, operands, immediate, ALU result).
REQ-002 Parameter CTRL_W, default 16, width of the control-signal payload (write-enable, memRead/memWrite, branch, jump, mux selects).
REQ-003 Parameter SKID, default 1; 1 = two-entry skid buffer with registered in_ready, 0 = single-entry register with combinational in_ready.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream stage presents a valid instruction.
REQ-007 in_ready  output  1  stage can accept an entry this cycle.
REQ-008 in_data  input  DATA_W  upstream datapath payload.
REQ-009 in_ctrl  input  CTRL_W  upstream control payload.
REQ-010 stall  input  1  global hold, e.g. cache busywait; freezes the stage.
REQ-011 flush  input  1  discard all held entries, e.g. branch mispredict.
REQ-012 out_valid  output  1  head entry valid.
REQ-013 out_ready  input  1  downstream stage accepts the head entry.
REQ-014 out_data  output  DATA_W  head datapath payload.
REQ-015 out_ctrl  output  CTRL_W  head control payload.
REQ-016 occupancy  output  2  number of held entries, 0..2.

Function
REQ-017 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready & !stall.
REQ-018 SKID=1: in_ready = !skid_valid & !stall & !flush & !reset; in_ready depends on no combinational input other than stall, flush and reset.
REQ-019 SKID=0: in_ready = (!main_valid | out_ready) & !stall & !flush & !reset.
REQ-020 Storage: main slot (drives out_*) and skid slot (SKID=1 only), each with its own valid bit.
REQ-021 Main empty, in_fire -> main <= input, main_valid=1 on the next edge (latency 1 cycle).
REQ-022 Main full, out_fire, skid valid -> main <= skid, skid_valid=0; a simultaneous in_fire is impossible because in_ready=0.
REQ-023 Main full, out_fire, skid empty, in_fire -> main <= input (back-to-back throughput, 1 entry/cycle).
REQ-024 Main full, out_fire, skid empty, no in_fire -> main_valid=0.
REQ-025 Main full, no out_fire, in_fire (SKID=1) -> skid <= input; main unchanged.
REQ-026 Entries leave in strict arrival order; no entry is duplicated or lost except by flush or reset.
REQ-027 stall=1 -> no in_fire, no out_fire, all state held; out_valid, out_data and out_ctrl are stable across the stall.
REQ-028 flush=1 -> on the next edge main_valid=0, skid_valid=0, occupancy=0.
REQ-029 flush has priority over stall and over in_valid; any entry offered in the flush cycle is discarded.
REQ-030 An out_fire in the flush cycle completes normally; the downstream stage owns that entry.
REQ-031 out_ctrl = 0 whenever out_valid = 0, so a bubble never asserts write-enable or memory strobes.
REQ-032 out_data holds its last value while out_valid = 0.
REQ-033 occupancy = main_valid + skid_valid, registered; with SKID=0, occupancy never exceeds 1.
REQ-034 Payload is passed bit-exact; no width conversion or sign extension.

Reset
REQ-035 With reset=1 at a rising edge: main_valid=0, skid_valid=0, out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
REQ-036 in_ready=0 while reset=1.
REQ-037 Reset mid-operation discards all held entries, with the same effect as flush plus clearing of out_data.
REQ-038 In the first cycle after reset deasserts, in_ready=1 (provided stall=0 and flush=0).

Verification
REQ-039 Streaming (DATA_W=32, CTRL_W=4, SKID=1), out_ready=1: inputs 0x100,0x104,0x108 on 3 consecutive cycles -> the same values appear on out_data on the 3 following cycles, out_ctrl=in_ctrl, occupancy constant at 1.
REQ-040 Backpressure: out_ready=0, offer 0xA then 0xB -> occupancy=2, in_ready=0; raise out_ready -> outputs 0xA then 0xB, in_ready returns to 1 one cycle after 0xA leaves.
REQ-041 Stall: main=0xC, occupancy=1, stall=1 for 3 cycles with in_valid=1 and out_ready=1 -> out_data=0xC held, in_ready=0, no transfers; on release 0xC leaves in 1 cycle.
REQ-042 Flush: occupancy=2 (0xD,0xE), flush=1 with in_valid=1 (0xF) -> next cycle out_valid=0, out_ctrl=0, occupancy=0; 0xF never appears.
REQ-043 Reset mid-stream: occupancy=2, reset=1 for 1 cycle -> all outputs 0; after release, 0x20 is accepted and emitted with latency 1.
REQ-044 SKID=0 build: out_ready=0 with main full -> in_ready=0 in the same cycle; out_ready=1 with main full and in_valid=1 -> entries are replaced back-to-back at full throughput.

Source files
------------

// File: rtl/pipeline_stage_skid.sv
// Pipeline register stage with valid/ready handshake, global stall and flush.
// SKID=1 adds a second slot so in_ready does not depend on out_ready.
module pipeline_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [1:0]        occupancy_q, occupancy_d;
    logic              in_fire, out_fire;

    generate
        if (SKID != 0) begin : g_skid_ready
            assign in_ready = !skid_valid_q && !stall && !flush && !reset;
        end else begin : g_reg_ready
            assign in_ready = (!main_valid_q || out_ready) && !stall && !flush && !reset;
        end
    endgenerate

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = main_valid_q && out_ready && !stall;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    // Bubbles must never present live control strobes downstream.
    assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
    assign occupancy = occupancy_q;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!stall) begin
            if (!main_valid_q) begin
                if (in_fire) begin
                    main_valid_d = 1'b1;
                    main_data_d  = in_data;
                    main_ctrl_d  = in_ctrl;
                end
            end else if (out_fire) begin
                if (skid_valid_q) begin
                    main_data_d  = skid_data_q;
                    main_ctrl_d  = skid_ctrl_q;
                    skid_valid_d = 1'b0;
                end else if (in_fire) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (in_fire) begin
                // Only reachable with a skid slot: in_ready is low otherwise.
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
                skid_ctrl_d  = in_ctrl;
            end
        end

        if (SKID == 0) begin
            skid_valid_d = 1'b0;
        end
        occupancy_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
            occupancy_q  <= 2'd0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            occupancy_q  <= occupancy_d;
        end
    end

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Randomized scoreboard bench: one SKID=1 and one SKID=0 instance, each with
// its own driver and monitor against a queue-based model of the stage.
module tb_pipeline_stage_skid;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int NCYC = 1500;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } entry_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int sk, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s skid=%0d t=%0t got=%h expected=%h", name, sk, $time, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int SK = (gi == 0) ? 1 : 0;

        logic          reset, in_valid, in_ready, stall, flush;
        logic          out_valid, out_ready;
        logic [DW-1:0] in_data, out_data;
        logic [CW-1:0] in_ctrl, out_ctrl;
        logic [1:0]    occupancy;

        entry_t        q[$];
        entry_t        pend_e;
        bit            pend;
        logic [DW-1:0] head_data;

        pipeline_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(SK)) dut (
            .clock     (clock),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .in_ctrl   (in_ctrl),
            .stall     (stall),
            .flush     (flush),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .out_ctrl  (out_ctrl),
            .occupancy (occupancy)
        );

        // Capacity rule: two slots with a skid buffer, otherwise one slot
        // that may be refilled in the same cycle it drains.
        function automatic bit exp_ready(input int sz);
            if (reset || stall || flush) return 1'b0;
            if (SK != 0) return sz < 2;
            return (sz == 0) || out_ready;
        endfunction

        initial begin : driver
            int mode;
            reset = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
            stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
            pend = 1'b0; mode = 0;
            repeat (2) @(posedge clock);
            for (int cyc = 0; ; cyc++) begin
                @(posedge clock);
                if (pend) q.push_back(pend_e);
                pend = 1'b0;
                #1;
                if (cyc % 32 == 0) mode = $urandom_range(0, 3);
                in_data = $urandom;
                in_ctrl = CW'($urandom);
                case (mode)
                    0: begin   // streaming
                        in_valid = 1'b1; out_ready = 1'b1; stall = 1'b0;
                        flush = 1'b0; reset = 1'b0;
                    end
                    1: begin   // backpressure
                        in_valid = ($urandom_range(0, 9) < 8);
                        out_ready = ($urandom_range(0, 9) < 2);
                        stall = 1'b0; flush = 1'b0; reset = 1'b0;
                    end
                    2: begin   // mixed
                        in_valid = ($urandom_range(0, 9) < 7);
                        out_ready = ($urandom_range(0, 9) < 6);
                        stall = ($urandom_range(0, 9) < 1);
                        flush = ($urandom_range(0, 19) < 1);
                        reset = ($urandom_range(0, 99) < 2);
                    end
                    default: begin   // hazards
                        in_valid = ($urandom_range(0, 9) < 8);
                        out_ready = ($urandom_range(0, 9) < 5);
                        stall = ($urandom_range(0, 9) < 4);
                        flush = ($urandom_range(0, 9) < 2);
                        reset = ($urandom_range(0, 49) < 2);
                    end
                endcase
                if (reset) out_ready = 1'b0;
                if (in_valid && exp_ready(q.size())) begin
                    pend   = 1'b1;
                    pend_e = '{d: in_data, c: in_ctrl};
                end
            end
        end

        initial begin : monitor
            int sz;
            entry_t e;
            head_data = '0;
            @(posedge clock);
            forever begin
                @(negedge clock);
                sz = q.size();
                if (sz > 0) head_data = q[0].d;
                chk("in_ready", SK, 64'(in_ready), 64'(exp_ready(sz)));
                chk("out_valid", SK, 64'(out_valid), 64'(sz > 0));
                chk("occupancy", SK, 64'(occupancy), 64'(sz));
                chk("out_data", SK, 64'(out_data), 64'(head_data));
                chk("out_ctrl", SK, 64'(out_ctrl), (sz > 0) ? 64'(q[0].c) : 64'd0);
                if (sz > 0 && out_ready && !stall && !reset) begin
                    e = q.pop_front();
                    $display("OUT skid=%0d t=%0t data=%h ctrl=%h", SK, $time, e.d, e.c);
                end
                if (flush || reset) q.delete();
                if (reset) head_data = '0;
            end
        end
    end

    initial begin
        repeat (NCYC) @(posedge clock);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
